// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, NWR prioritised writes,
// optional same-cycle write forwarding and a pending-write scoreboard.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NWR-1:0]                   we,
  input  logic [NWR*$clog2(NREGS)-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0]            wdata,
  input  logic [NRD*$clog2(NREGS)-1:0]     raddr,
  output logic [NRD*DATA_W-1:0]            rdata,
  input  logic                             iss_valid,
  input  logic [$clog2(NREGS)-1:0]         iss_dst,
  output logic [NRD-1:0]                   rd_busy,
  output logic                             busy_any,
  output logic                             wr_collide
);

  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  pend_nxt;
  logic              collide_now;

  // Register 0 and out-of-range addresses (non-power-of-2 NREGS) never hold state.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREGS);
  endfunction

  always_comb begin
    collide_now = 1'b0;
    for (int unsigned j = 0; j < NWR; j++) begin
      for (int unsigned k = j + 1; k < NWR; k++) begin
        if (we[j] && we[k] && addr_ok(waddr[j*AW +: AW]) &&
            (waddr[j*AW +: AW] == waddr[k*AW +: AW]))
          collide_now = 1'b1;
      end
    end
  end

  // Clears are applied first so a same-cycle issue to the same register wins.
  always_comb begin
    pend_nxt = pend;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (we[j] && addr_ok(waddr[j*AW +: AW]))
        pend_nxt[waddr[j*AW +: AW]] = 1'b0;
    end
    if (iss_valid && addr_ok(iss_dst))
      pend_nxt[iss_dst] = 1'b1;
  end

  // Ascending port order: the last (highest-index) assignment takes effect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREGS; r++)
        regs[r] <= '0;
      pend       <= '0;
      wr_collide <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (we[j] && addr_ok(waddr[j*AW +: AW]))
          regs[waddr[j*AW +: AW]] <= wdata[j*DATA_W +: DATA_W];
      end
      pend <= pend_nxt;
      if (collide_now)
        wr_collide <= 1'b1;
    end
  end

  always_comb begin : read_ports
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    logic              b;
    a       = '0;
    d       = '0;
    b       = 1'b0;
    rdata   = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      a = raddr[i*AW +: AW];
      d = '0;
      b = 1'b0;
      if (addr_ok(a)) begin
        d = regs[a];
        b = pend[a];
        if (BYPASS != 0) begin
          for (int unsigned j = 0; j < NWR; j++) begin
            if (we[j] && (waddr[j*AW +: AW] == a)) begin
              d = wdata[j*DATA_W +: DATA_W];
              b = 1'b0;
            end
          end
        end
      end
      rdata[i*DATA_W +: DATA_W] = d;
      rd_busy[i]                = b;
    end
  end

  assign busy_any = |pend;

endmodule
